eth_rx_frame_parser: RTL

Parametrised successor to the byte-wide GMII RX parser. Walks each GMII frame through preamble, SFD, destination MAC, source MAC, optional 802.1Q tag and EtherType, then forwards payload+CRC bytes as a valid/last stream. Reports per-frame length and error status. Sits between the GMII RX pins and the CRC checker / RX FIFO.

---
 rtl/eth_rx_frame_parser.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_frame_parser.sv
// eth_rx_frame_parser: byte-wide GMII RX header parser with payload+FCS forwarding and per-frame status
module eth_rx_frame_parser #(
  parameter int DATA_W = 8,
  parameter int PREAMBLE_LEN = 7,
  parameter int STRICT_PREAMBLE = 1,
  parameter int VLAN_EN = 1,
  parameter int MIN_DATA_LEN = 46,
  parameter int MAX_DATA_LEN = 1500,
  parameter int CRC_LEN = 4,
  parameter logic [7:0] PREAMBLE_BYTE = 8'hAA,
  parameter logic [7:0] SFD_BYTE = 8'hAB,
  localparam int LEN_W = $clog2(MAX_DATA_LEN + CRC_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gmii_rx_dv,
  input  logic              gmii_rx_er,
  input  logic [DATA_W-1:0] gmii_rxd,
  output logic [47:0]       dst_mac,
  output logic [47:0]       src_mac,
  output logic [15:0]       ether_type,
  output logic              vlan_valid,
  output logic [15:0]       vlan_tci,
  output logic              hdr_valid,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_err,
  output logic              frame_done,
  output logic [LEN_W-1:0]  frame_len,
  output logic [5:0]        frame_err
);
  localparam logic [7:0] PL = 8'(PREAMBLE_LEN);
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_DATA_LEN + CRC_LEN);
  localparam logic [LEN_W-1:0] LMIN = LEN_W'(MIN_DATA_LEN + CRC_LEN);
  typedef enum logic [3:0] {IDLE, PRE, SFD, DST, SRC, ETYPE, VTCI, ETYPE2, PAYLOAD, DROP} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic prev_dv_q, prev_dv_d;
  logic [5:0] err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] hold_q, hold_d, od_q, od_d;
  logic hold_v_q, hold_v_d;
  logic [95:0] mac_sh_q, mac_sh_d;
  logic [15:0] wd_sh_q, wd_sh_d, tci_sh_q, tci_sh_d;
  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic [15:0] et_q, et_d, vtci_q, vtci_d;
  logic vv_q, vv_d, hdr_v_q, hdr_v_d, ov_q, ov_d, ol_q, ol_d, oe_q, oe_d, fd_q, fd_d;
  logic start, hdr_state;
  logic [7:0] pcnt, pinc;
  logic [15:0] hw;
  assign start = gmii_rx_dv & ~prev_dv_q;
  assign hdr_state = state_q inside {SFD, DST, SRC, ETYPE, VTCI, ETYPE2};
  // the first preamble byte is consumed in IDLE, so it counts from zero there
  assign pcnt = (state_q == IDLE) ? 8'd0 : cnt_q;
  assign pinc = pcnt + 8'd1;
  assign hw = {wd_sh_q[7:0], gmii_rxd};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    prev_dv_d = gmii_rx_dv;
    err_d = (state_q == IDLE && start) ? '0 : err_q;
    err_d[5] = err_d[5] | (gmii_rx_dv & gmii_rx_er & (state_q != IDLE | start));
    len_d = (state_q == IDLE && start) ? '0 : len_q;
    hold_d = hold_q;
    hold_v_d = hold_v_q;
    mac_sh_d = mac_sh_q;
    wd_sh_d = gmii_rx_dv ? hw : wd_sh_q;
    tci_sh_d = tci_sh_q;
    dst_d = dst_q;
    src_d = src_q;
    et_d = et_q;
    vv_d = vv_q;
    vtci_d = vtci_q;
    hdr_v_d = 1'b0;
    ov_d = 1'b0;
    ol_d = 1'b0;
    oe_d = 1'b0;
    fd_d = 1'b0;
    if (hdr_state && !gmii_rx_dv) begin
      err_d[2] = 1'b1;
      fd_d = 1'b1;
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE, PRE: begin
          if (state_q == PRE || start) begin
            if (!gmii_rx_dv) begin
              err_d[0] = 1'b1;
              fd_d = 1'b1;
              state_d = IDLE;
              cnt_d = '0;
            end else if (gmii_rxd == PREAMBLE_BYTE) begin
              state_d = (pinc == PL) ? SFD : PRE;
              cnt_d = (pinc == PL) ? 8'd0 : pinc;
            end else if (gmii_rxd == SFD_BYTE && STRICT_PREAMBLE == 0 && pcnt != 8'd0) begin
              state_d = DST;
              cnt_d = '0;
            end else begin
              err_d[0] = 1'b1;
              state_d = DROP;
              cnt_d = '0;
            end
          end
        end
        SFD: begin
          err_d[1] = err_d[1] | (gmii_rxd != SFD_BYTE);
          state_d = (gmii_rxd == SFD_BYTE) ? DST : DROP;
          cnt_d = '0;
        end
        DST, SRC: begin
          mac_sh_d = {mac_sh_q[87:0], gmii_rxd};
          state_d = (cnt_q != 8'd5) ? state_q : (state_q == DST) ? SRC : ETYPE;
          cnt_d = (cnt_q == 8'd5) ? 8'd0 : cnt_q + 8'd1;
        end
        ETYPE, VTCI, ETYPE2: begin
          cnt_d = (cnt_q == 8'd0) ? 8'd1 : 8'd0;
          if (cnt_q != 8'd0) begin
            if (state_q == VTCI) begin
              tci_sh_d = hw;
              state_d = ETYPE2;
            end else if (state_q == ETYPE && VLAN_EN != 0 && hw == 16'h8100) begin
              state_d = VTCI;
            end else begin
              state_d = PAYLOAD;
              hdr_v_d = 1'b1;
              dst_d = mac_sh_q[95:48];
              src_d = mac_sh_q[47:0];
              et_d = hw;
              vv_d = state_q == ETYPE2;
              vtci_d = (state_q == ETYPE2) ? tci_sh_q : 16'h0000;
            end
          end
        end
        PAYLOAD: begin
          ov_d = hold_v_q;
          if (!gmii_rx_dv) begin
            err_d[3] = len_q < LMIN;
            ol_d = hold_v_q;
            oe_d = hold_v_q & (|err_d);
            fd_d = 1'b1;
            hold_v_d = 1'b0;
            state_d = IDLE;
          end else if (len_q == LMAX) begin
            err_d[4] = 1'b1;
            ol_d = hold_v_q;
            oe_d = hold_v_q;
            hold_v_d = 1'b0;
            state_d = DROP;
          end else begin
            hold_d = gmii_rxd;
            hold_v_d = 1'b1;
            len_d = len_q + 1'b1;
          end
        end
        DROP: begin
          fd_d = ~gmii_rx_dv;
          state_d = gmii_rx_dv ? DROP : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    od_d = ov_d ? hold_q : od_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      prev_dv_q <= 1'b1;
      err_q <= '0;
      len_q <= '0;
      hold_q <= '0;
      hold_v_q <= 1'b0;
      mac_sh_q <= '0;
      wd_sh_q <= '0;
      tci_sh_q <= '0;
      dst_q <= '0;
      src_q <= '0;
      et_q <= '0;
      vv_q <= 1'b0;
      vtci_q <= '0;
      hdr_v_q <= 1'b0;
      ov_q <= 1'b0;
      od_q <= '0;
      ol_q <= 1'b0;
      oe_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      prev_dv_q <= prev_dv_d;
      err_q <= err_d;
      len_q <= len_d;
      hold_q <= hold_d;
      hold_v_q <= hold_v_d;
      mac_sh_q <= mac_sh_d;
      wd_sh_q <= wd_sh_d;
      tci_sh_q <= tci_sh_d;
      dst_q <= dst_d;
      src_q <= src_d;
      et_q <= et_d;
      vv_q <= vv_d;
      vtci_q <= vtci_d;
      hdr_v_q <= hdr_v_d;
      ov_q <= ov_d;
      od_q <= od_d;
      ol_q <= ol_d;
      oe_q <= oe_d;
      fd_q <= fd_d;
    end
  end
  assign dst_mac = dst_q;
  assign src_mac = src_q;
  assign ether_type = et_q;
  assign vlan_valid = vv_q;
  assign vlan_tci = vtci_q;
  assign hdr_valid = hdr_v_q;
  assign out_valid = ov_q;
  assign out_data = od_q;
  assign out_last = ol_q;
  assign out_err = oe_q;
  assign frame_done = fd_q;
  assign frame_len = len_q;
  assign frame_err = err_q;
endmodule
